// File: rtl/extbus_master_6502_if.sv
// Host command/response and 65C02-style external bus signals of extbus_master_6502.
interface extbus_master_6502_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wrdata;
    logic       rsp_valid;
    logic [7:0] rsp_rddata;
    logic       extbus_phi2;
    logic       extbus_cs_n;
    logic       extbus_rw_n;
    logic [2:0] extbus_a;
    logic [7:0] extbus_d_out;
    logic       extbus_d_oe;
    logic [7:0] extbus_d_in;
    logic       extbus_rdy;
    logic       extbus_irq_n;
    logic       irq;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wrdata,
        input  extbus_d_in, extbus_rdy, extbus_irq_n,
        output cmd_ready, rsp_valid, rsp_rddata,
        output extbus_phi2, extbus_cs_n, extbus_rw_n, extbus_a,
        output extbus_d_out, extbus_d_oe, irq
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wrdata,
        output extbus_d_in, extbus_rdy, extbus_irq_n,
        input  cmd_ready, rsp_valid, rsp_rddata,
        input  extbus_phi2, extbus_cs_n, extbus_rw_n, extbus_a,
        input  extbus_d_out, extbus_d_oe, irq
    );
endinterface

// File: rtl/extbus_master_6502.sv
// 65C02-style bus initiator: free-running phi2, one bus cycle per host command,
// RDY stall repeats the cycle, synchronized IRQ.
module extbus_master_6502 #(
    parameter int unsigned PHI2_LOW_CLKS  = 4,
    parameter int unsigned PHI2_HIGH_CLKS = 4
) (
    input  logic                     bm_clk,
    input  logic                     bm_reset,
    extbus_master_6502_if.master     bus
);
    localparam int unsigned PERIOD = PHI2_LOW_CLKS + PHI2_HIGH_CLKS;
    localparam int unsigned CW     = $clog2(PERIOD);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          last;

    logic          pend_valid;
    logic          pend_write;
    logic [2:0]    pend_addr;
    logic [7:0]    pend_data;

    logic          rdy_meta;
    logic          rdy_sync;
    logic          irq_meta;

    always_comb begin
        last     = (cnt == CW'(PERIOD - 1));
        cnt_next = last ? '0 : cnt + CW'(1);
    end

    assign bus.cmd_ready = !pend_valid;

    // Synchronizers; rdy resets high to match its external pull-up.
    always_ff @(posedge bm_clk or posedge bm_reset) begin
        if (bm_reset) begin
            rdy_meta <= 1'b1;
            rdy_sync <= 1'b1;
            irq_meta <= 1'b0;
            bus.irq  <= 1'b0;
        end else begin
            rdy_meta <= bus.extbus_rdy;
            rdy_sync <= rdy_meta;
            irq_meta <= !bus.extbus_irq_n;
            bus.irq  <= irq_meta;
        end
    end

    always_ff @(posedge bm_clk or posedge bm_reset) begin
        if (bm_reset) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            pend_valid       <= 1'b0;
            pend_write       <= 1'b0;
            pend_addr        <= '0;
            pend_data        <= '0;
            bus.extbus_phi2  <= 1'b0;
            bus.extbus_cs_n  <= 1'b1;
            bus.extbus_rw_n  <= 1'b1;
            bus.extbus_a     <= '0;
            bus.extbus_d_out <= '0;
            bus.extbus_d_oe  <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rddata   <= '0;
        end else begin
            cnt             <= cnt_next;
            bus.extbus_phi2 <= (cnt_next >= CW'(PHI2_LOW_CLKS));
            bus.rsp_valid   <= 1'b0;

            if (bus.cmd_valid && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_write <= bus.cmd_write;
                pend_addr  <= bus.cmd_addr;
                pend_data  <= bus.cmd_wrdata;
            end

            // A stalled cycle (rdy low on its last clock) leaves every bus output untouched.
            if (last && !(state == ST_ACTIVE && !rdy_sync)) begin
                if (state == ST_ACTIVE) begin
                    bus.rsp_valid <= 1'b1;
                    if (bus.extbus_rw_n)
                        bus.rsp_rddata <= bus.extbus_d_in;
                end
                if (pend_valid) begin
                    state           <= ST_ACTIVE;
                    pend_valid      <= 1'b0;
                    bus.extbus_cs_n <= 1'b0;
                    bus.extbus_rw_n <= !pend_write;
                    bus.extbus_a    <= pend_addr;
                    if (pend_write)
                        bus.extbus_d_out <= pend_data;
                end else begin
                    state           <= ST_IDLE;
                    bus.extbus_cs_n <= 1'b1;
                    bus.extbus_rw_n <= 1'b1;
                end
            end

            // cs_n/rw_n cannot change on a clock entering the high phase, so current values apply.
            bus.extbus_d_oe <= (cnt_next >= CW'(PHI2_LOW_CLKS)) &&
                               !bus.extbus_cs_n && !bus.extbus_rw_n;
        end
    end
endmodule
